// File: rtl/pmp_types_1_12_pkg.sv
// Shared PMP types and constants for the priv 1.12 PMP register file.
package pmp_types_1_12_pkg;

  localparam int unsigned PMP_MINIMUM_GRANULARITY = 0;
  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_a_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_base_t;

  typedef logic [31:0] pmpaddr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } pmp_fsm_t;

  function automatic pmpaddr_t low_mask(input int unsigned bits);
    return (32'h1 << bits) - 32'h1;
  endfunction

endpackage

// File: rtl/priv_1_12_pmp_cfg_legalizer.sv
// WARL legalization of one pmpcfg byte: reserved bits, R=0/W=1, NA4 under coarse
// granularity, and the lock hold when lock_en is set.
module priv_1_12_pmp_cfg_legalizer
  import pmp_types_1_12_pkg::*;
#(
  parameter int unsigned GRAN = PMP_MINIMUM_GRANULARITY
) (
  input  pmpcfg_base_t old_cfg,
  input  pmpcfg_base_t new_cfg,
  input  logic         lock_en,
  output pmpcfg_base_t legal_cfg
);

  always_comb begin
    legal_cfg      = new_cfg;
    legal_cfg.rsvd = 2'b00;
    legal_cfg.l    = new_cfg.l & lock_en;
    legal_cfg.w    = new_cfg.w & new_cfg.r;
    // NA4 is not selectable once the grain exceeds 4 bytes
    if ((GRAN >= 32'd1) && (new_cfg.a == NA4)) begin
      legal_cfg.a = old_cfg.a;
    end else begin
      legal_cfg.a = new_cfg.a;
    end
    if (lock_en && old_cfg.l) begin
      legal_cfg = old_cfg;
    end else begin
      legal_cfg.x = new_cfg.x;
    end
  end

endmodule

// File: rtl/priv_1_12_pmp_regfile.sv
// PMP pmpcfg/pmpaddr register file with a 3-state CSR req/ack port.
// Define PMP_LOCK_EN to store L bits and enforce the lock rules.
module priv_1_12_pmp_regfile
  import pmp_types_1_12_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned GRAN        = PMP_MINIMUM_GRANULARITY
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             csr_req,
  input  logic                             csr_we,
  input  logic [11:0]                      csr_addr,
  input  logic [31:0]                      csr_wdata,
  output logic                             csr_ack,
  output logic [31:0]                      csr_rdata,
  output logic                             csr_illegal,
  output pmpcfg_base_t [NUM_ENTRIES-1:0]   pmp_cfg,
  output pmpaddr_t     [NUM_ENTRIES-1:0]   pmp_addr,
  output logic                             cfg_update
);

  localparam pmpaddr_t GRAN_MASK  = low_mask(GRAN);
  localparam pmpaddr_t NAPOT_MASK = (GRAN >= 32'd2) ? low_mask(GRAN - 32'd1) : 32'h0;

  pmp_fsm_t state_r, state_s;
  logic        we_r;
  logic [11:0] addr_r;
  logic [31:0] wdata_r;
  logic        ack_r, illegal_r, update_r, commit_r;
  logic [31:0] rdata_r;
  pmpcfg_base_t [NUM_ENTRIES-1:0] cfg_r, legal_cfg_s, new_cfg_s;
  pmpaddr_t     [NUM_ENTRIES-1:0] paddr_r, new_addr_s;
  logic [NUM_ENTRIES-1:0] addr_locked_s;
  logic        is_cfg_s, is_addr_s, illegal_s, update_s;
  logic [31:0] rdata_s;

`ifdef PMP_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
  // pmpaddr i is frozen by its own L bit or by a locked TOR entry above it
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_lock
    if (i + 1 < NUM_ENTRIES) begin : g_tor
      assign addr_locked_s[i] = cfg_r[i].l | (cfg_r[i+1].l & (cfg_r[i+1].a == TOR));
    end else begin : g_last
      assign addr_locked_s[i] = cfg_r[i].l;
    end
  end
`else
  localparam logic LOCK_EN = 1'b0;
  assign addr_locked_s = '0;
`endif

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_legal
    priv_1_12_pmp_cfg_legalizer #(.GRAN(GRAN)) u_legal (
      .old_cfg   (cfg_r[i]),
      .new_cfg   (pmpcfg_base_t'(wdata_r[8*(i%4) +: 8])),
      .lock_en   (LOCK_EN),
      .legal_cfg (legal_cfg_s[i])
    );
  end

  assign is_cfg_s  = (addr_r[11:2] == PMPCFG_BASE[11:2]);
  assign is_addr_s = (addr_r[11:4] == PMPADDR_BASE[11:4]);

  // Decode the snapshot: old readback value and candidate new state.
  // Unimplemented entries simply never match, so they read 0 and drop writes.
  always_comb begin
    rdata_s    = 32'h0;
    illegal_s  = 1'b0;
    new_cfg_s  = cfg_r;
    new_addr_s = paddr_r;
    if (is_cfg_s) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if ((i / 4) == int'(addr_r[1:0])) begin
          rdata_s[8*(i%4) +: 8] = cfg_r[i];
          new_cfg_s[i]          = legal_cfg_s[i];
        end else begin
          new_cfg_s[i] = cfg_r[i];
        end
      end
    end else if (is_addr_s) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (i == int'(addr_r[3:0])) begin
          if (cfg_r[i].a == NAPOT) begin
            rdata_s = paddr_r[i] | NAPOT_MASK;
          end else begin
            rdata_s = paddr_r[i] & ~GRAN_MASK;
          end
          if (!addr_locked_s[i]) begin
            new_addr_s[i] = pmpaddr_t'(wdata_r) & ~GRAN_MASK;
          end else begin
            new_addr_s[i] = paddr_r[i];
          end
        end else begin
          new_addr_s[i] = paddr_r[i];
        end
      end
    end else begin
      illegal_s = 1'b1;
    end
  end

  assign update_s = we_r & ~illegal_s & ((new_cfg_s != cfg_r) | (new_addr_s != paddr_r));

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (csr_req) state_s = CHECK; else state_s = IDLE;
      CHECK:   state_s = COMMIT;
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      we_r      <= 1'b0;
      addr_r    <= 12'h0;
      wdata_r   <= 32'h0;
      ack_r     <= 1'b0;
      illegal_r <= 1'b0;
      update_r  <= 1'b0;
      commit_r  <= 1'b0;
      rdata_r   <= 32'h0;
    end else begin
      state_r   <= state_s;
      ack_r     <= (state_r == CHECK);
      illegal_r <= (state_r == CHECK) & illegal_s;
      update_r  <= (state_r == CHECK) & update_s;
      commit_r  <= (state_r == CHECK) & we_r & ~illegal_s;
      rdata_r   <= (state_r == CHECK) ? rdata_s : 32'h0;
      if ((state_r == IDLE) && csr_req) begin
        we_r    <= csr_we;
        addr_r  <= csr_addr;
        wdata_r <= csr_wdata;
      end else begin
        we_r    <= we_r;
      end
    end
  end

  // State only moves at the end of COMMIT; reset wins over a pending commit
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_r   <= '0;
      paddr_r <= '0;
    end else if ((state_r == COMMIT) && commit_r) begin
      cfg_r   <= new_cfg_s;
      paddr_r <= new_addr_s;
    end else begin
      cfg_r   <= cfg_r;
    end
  end

  assign csr_ack     = ack_r;
  assign csr_illegal = illegal_r;
  assign csr_rdata   = rdata_r;
  assign cfg_update  = update_r;
  assign pmp_cfg     = cfg_r;
  assign pmp_addr    = paddr_r;

endmodule

// File: doc/priv_1_12_pmp_regfile.md
# priv_1_12_pmp_regfile

Register file and CSR write port for the PMP unit. It holds all pmpcfg/pmpaddr state, applies RISC-V priv 1.12 WARL legalization and lock rules on every CSR access, and drives the entry arrays consumed by the per-entry PMP matchers. It sits between the priv CSR block (initiator) and the PMP checker (reader). Each access is a 3-state req/ack transaction.

## Interface
- NUM_ENTRIES, default 16: implemented PMP entries, 0..16 in multiples of 4.
- GRAN, default PMP_MINIMUM_GRANULARITY: G; region granularity is 2^(G+2) bytes.
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- csr_req  in  1  access request; held until csr_ack.
- csr_we  in  1  1 = write, 0 = read only.
- csr_addr  in  12  CSR number.
- csr_wdata  in  32  write data.
- csr_ack  out  1  one-cycle completion pulse.
- csr_rdata  out  32  pre-write value of the CSR, valid with csr_ack.
- csr_illegal  out  1  valid with csr_ack; csr_addr is outside 0x3A0–0x3A3 and 0x3B0–0x3BF.
- pmp_cfg  out  NUM_ENTRIES×pmpcfg_base_t  registered per-entry configuration.
- pmp_addr  out  NUM_ENTRIES×pmpaddr_t  registered per-entry address.
- cfg_update  out  1  one-cycle pulse when any committed bit changed.

## Operation
- FSM states: IDLE, CHECK, COMMIT.
  - IDLE → CHECK when csr_req=1. The request is latched into snapshot registers: we, addr, wdata.
  - CHECK → COMMIT always. Decode the snapshot, compute legalized new values and the old readback value, and register them.
  - COMMIT → IDLE always. If we=1 and the address is legal, write the legalized values. Pulse csr_ack.
- csr_req is ignored outside IDLE.
- Address map:
  - pmpcfgN (0x3A0+N) packs entries 4N..4N+3, one byte each: {L, 2'b0, A[1:0], X, W, R}.
  - pmpaddrN (0x3B0+N) holds entry N.
  - A CSR whose entries are not implemented (index ≥ NUM_ENTRIES) reads 0, ignores writes, and is not illegal.
- Illegal address: csr_ack=1, csr_illegal=1, csr_rdata=0, no state change.
- cfg byte legalization, evaluated per byte:
  - Bits [6:5] are forced to 0.
  - R=0 with W=1 is reserved and is written as W=0.
  - If G≥1 and A=NA4, the previous A field is kept.
- pmpaddr legalization: for G≥1, stored bits [G-1:0] are forced to 0.
- pmpaddr readback, for G≥2:
  - A=NAPOT: bits [G-2:0] read as 1.
  - A=OFF or TOR: bits [G-1:0] read as 0.
- Lock rules:
  - Entry i with L=1 ignores writes to its cfg byte and to pmpaddr i.
  - pmpaddr i also ignores writes when entry i+1 has L=1 and A=TOR.
  - In a packed pmpcfg write, locked bytes keep their old value and unlocked bytes update.
- cfg_update=1 in the COMMIT cycle if and only if the committed values differ from the old values.

## Timing
- Latency: a csr_req sampled high at edge T gives csr_ack high in cycle T+2.
- The requester must drop csr_req in the ack cycle. If csr_req is still high in IDLE, it starts a new transaction.
- pmp_cfg and pmp_addr change at the edge that ends COMMIT. Matchers see the new values one cycle after csr_ack.
- Reset values:
  - FSM in IDLE.
  - All pmp_cfg = 0: A=OFF, L=0.
  - All pmp_addr = 0.
  - csr_ack=0, csr_illegal=0, cfg_update=0, csr_rdata=0.
- RST asserted in CHECK or COMMIT aborts the transaction: no commit, no ack. Reset has priority over a COMMIT in the same cycle.
- Back-to-back transactions: the minimum spacing is 3 cycles, and each observes the previous commit.

## Configuration
- PMP_LOCK_EN defined: L bits are stored and all lock rules apply.
- PMP_LOCK_EN undefined:
  - Bit 7 of every cfg byte is written as 0 and reads as 0.
  - Every entry is always writable.
  - The lock comparison logic is not synthesized.

## Structure
- pmp_types_1_12_pkg owns the shared definitions:
  - pmpcfg_base_t, pmpaddr_t, and the A-field enum (OFF/TOR/NA4/NAPOT).
  - PMP_MINIMUM_GRANULARITY.
  - New constants PMPCFG_BASE=12'h3A0 and PMPADDR_BASE=12'h3B0.
  - A new typedef pmp_fsm_t {IDLE, CHECK, COMMIT}.
- Sub-module priv_1_12_pmp_cfg_legalizer: combinational, one instance per cfg byte.
  - Inputs: old byte, new byte, lock-enable.
  - Output: the legalized byte.

## Test plan
- Reset then read 0x3A0 → ack in cycle 2, rdata=0, illegal=0, all pmp_cfg A=OFF.
- Write 0x3B0=0x2000_0000, then 0x3A0=0x0000_000F → pmp_addr[0]=0x2000_0000; pmp_cfg[0]: R=W=X=1, A=TOR; cfg_update pulses both times; a rewrite of the same value gives no pulse.
- Write 0x3A0 byte0=0x02 (R=0, W=1) → stored 0x00; write byte0=0xFF → stored 0x9F (bits [6:5] cleared).
- PMP_LOCK_EN:
  - Set entry1 = 0x88 (L=1, A=TOR).
  - Write 0x3B1 and 0x3B0 = 0xFFFF_FFFF → both unchanged.
  - Write 0x3A0 = 0x0000_0007 → byte1 stays 0x88, byte0 = 0x07.
- Access 0x3A5 with we=1 → ack with illegal=1, rdata=0, no state change, no cfg_update.
- Assert RST in the CHECK cycle of a write to 0x3B2=0x1234 → no ack; pmp_addr[2]=0 afterward; FSM is in IDLE.
